// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: slave end of the multiplexed RTC parallel bus.
// Emulates an external RTC: latches an address, accepts writes, returns read
// data, and keeps a BCD time-of-day (HR:MIN:SEC) running off a clk prescaler.
//
// Optional feature macro: RTC_ALARM_IRQ_EN
//   defined   -> alarm registers, STATUS alarm flag and active-low IRQ
//   undefined -> alarm registers and STATUS read 0x00, irq_n_o tied high
//
// Ports
//   clk        system clock (single domain)
//   rst_n      asynchronous active-low reset
//   cs_n_i     chip select, active low (asynchronous to clk)
//   rd_n_i     read strobe, active low
//   wr_n_i     write strobe, active low
//   ad_i       0 = address phase, 1 = data phase
//   din_i      address or write data from the controller
//   dout_o     read data to the bus
//   dout_en_o  1 = responder drives the bus
//   irq_n_o    alarm interrupt, active low
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n_i,
  input  logic       rd_n_i,
  input  logic       wr_n_i,
  input  logic       ad_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       dout_en_o,
  output logic       irq_n_o
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [7:0] ADDR_SEC    = 8'h00;
  localparam logic [7:0] ADDR_MIN    = 8'h01;
  localparam logic [7:0] ADDR_HR     = 8'h02;
  localparam logic [7:0] ADDR_CTRL   = 8'h06;
  localparam logic [7:0] ADDR_STATUS = 8'h07;
`ifdef RTC_ALARM_IRQ_EN
  localparam logic [7:0] ADDR_ASEC   = 8'h03;
  localparam logic [7:0] ADDR_AMIN   = 8'h04;
  localparam logic [7:0] ADDR_AHR    = 8'h05;
`endif

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRIVE = 1'b1
  } rd_state_e;

  // BCD increment with wrap after 'last'; out-of-range values wrap to 0x00.
  // Returns {carry, next}.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if ((v >= last) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9)) begin
      return {1'b1, 8'h00};
    end else if (v[3:0] == 4'd9) begin
      return {1'b0, v[7:4] + 4'd1, 4'h0};
    end else begin
      return {1'b0, v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // Bus input synchronisers; reset to the idle (all ones) bus state
  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q, ad_sync_q;
  logic                   wr_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      ad_sync_q <= '1;
      wr_prev_q <= 1'b1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_n_i};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_n_i};
      ad_sync_q <= {ad_sync_q[SYNC_STAGES-2:0], ad_i};
      wr_prev_q <= wr_sync_q[SYNC_STAGES-1];
    end
  end

  logic cs_s_c, wr_s_c, ad_s_c;
  logic wr_rise_c, addr_wr_c, data_wr_c;
  logic read_cond_c;

  assign cs_s_c = cs_sync_q[SYNC_STAGES-1];
  assign wr_s_c = wr_sync_q[SYNC_STAGES-1];
  assign ad_s_c = ad_sync_q[SYNC_STAGES-1];

  assign wr_rise_c = ~wr_prev_q & wr_s_c & ~cs_s_c;
  assign addr_wr_c = wr_rise_c & ~ad_s_c;
  assign data_wr_c = wr_rise_c & ad_s_c;

  // Read condition taken one stage early so the registered enable lands
  // SYNC_STAGES cycles after the pins; a concurrent low WR suppresses it.
  assign read_cond_c = ~cs_sync_q[SYNC_STAGES-2] & ~rd_sync_q[SYNC_STAGES-2] &
                       ad_sync_q[SYNC_STAGES-2] & wr_sync_q[SYNC_STAGES-2];

  // Register file state
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic             run_q, run_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_c;
  logic [8:0]       sec_inc_c, min_inc_c, hr_inc_c;
`ifdef RTC_ALARM_IRQ_EN
  logic [7:0]       asec_q, asec_d, amin_q, amin_d, ahr_q, ahr_d;
  logic             alarm_q, alarm_d;
  logic             tick_q;
  logic             irq_n_q, irq_n_d;
  logic             match_c;
`endif

  assign tick_c    = run_q && (pre_q == PRE_LAST);
  assign sec_inc_c = bcd_inc(sec_q, 8'h59);
  assign min_inc_c = bcd_inc(min_q, 8'h59);
  assign hr_inc_c  = bcd_inc(hr_q, 8'h23);
`ifdef RTC_ALARM_IRQ_EN
  assign match_c   = (hr_q == ahr_q) && (min_q == amin_q) && (sec_q == asec_q);
`endif

  // Next-state for address latch, time, prescaler, control and alarm
  always_comb begin
    addr_d = addr_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    run_d  = run_q;
    pre_d  = pre_q;
`ifdef RTC_ALARM_IRQ_EN
    asec_d  = asec_q;
    amin_d  = amin_q;
    ahr_d   = ahr_q;
    alarm_d = alarm_q;
`endif

    if (run_q) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    end

    // Ripple carry through the time registers
    if (tick_c) begin
      sec_d = sec_inc_c[7:0];
      if (sec_inc_c[8]) begin
        min_d = min_inc_c[7:0];
        if (min_inc_c[8]) begin
          hr_d = hr_inc_c[7:0];
        end
      end
    end

    if (addr_wr_c) begin
      addr_d = din_i;
    end

    // Bus write overrides that register's tick increment
    if (data_wr_c) begin
      case (addr_q)
        ADDR_SEC: begin
          sec_d = din_i;
          pre_d = '0;
        end
        ADDR_MIN:  min_d = din_i;
        ADDR_HR:   hr_d  = din_i;
        ADDR_CTRL: run_d = din_i[0];
`ifdef RTC_ALARM_IRQ_EN
        ADDR_ASEC: asec_d = din_i;
        ADDR_AMIN: amin_d = din_i;
        ADDR_AHR:  ahr_d  = din_i;
`endif
        default: ;
      endcase
    end

`ifdef RTC_ALARM_IRQ_EN
    // Clear first so a same-cycle match sets the flag
    if (data_wr_c && (addr_q == ADDR_CTRL) && din_i[1]) begin
      alarm_d = 1'b0;
    end
    if (tick_q && match_c) begin
      alarm_d = 1'b1;
    end
    irq_n_d = ~alarm_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 8'h00;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hr_q   <= 8'h00;
      run_q  <= 1'b1;
      pre_q  <= '0;
    end else begin
      addr_q <= addr_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      run_q  <= run_d;
      pre_q  <= pre_d;
    end
  end

`ifdef RTC_ALARM_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asec_q  <= 8'h00;
      amin_q  <= 8'h00;
      ahr_q   <= 8'h00;
      alarm_q <= 1'b0;
      tick_q  <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      asec_q  <= asec_d;
      amin_q  <= amin_d;
      ahr_q   <= ahr_d;
      alarm_q <= alarm_d;
      tick_q  <= tick_c;
      irq_n_q <= irq_n_d;
    end
  end

  assign irq_n_o = irq_n_q;
`else
  assign irq_n_o = 1'b1;
`endif

  // Read data multiplexer
  logic [7:0] rd_data_c;

  always_comb begin
    rd_data_c = 8'h00;
    case (addr_q)
      ADDR_SEC:    rd_data_c = sec_q;
      ADDR_MIN:    rd_data_c = min_q;
      ADDR_HR:     rd_data_c = hr_q;
      ADDR_CTRL:   rd_data_c = {7'b0, run_q};
`ifdef RTC_ALARM_IRQ_EN
      ADDR_ASEC:   rd_data_c = asec_q;
      ADDR_AMIN:   rd_data_c = amin_q;
      ADDR_AHR:    rd_data_c = ahr_q;
      ADDR_STATUS: rd_data_c = {7'b0, alarm_q};
`else
      ADDR_STATUS: rd_data_c = 8'h00;
`endif
      default:     rd_data_c = 8'h00;
    endcase
  end

  // Read drive FSM: capture data on entry, hold it while the read persists
  rd_state_e  rd_state_q, rd_state_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_en_q, dout_en_d;

  always_comb begin
    rd_state_d = rd_state_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (read_cond_c) begin
          rd_state_d = RD_DRIVE;
          dout_d     = rd_data_c;
        end
      end
      RD_DRIVE: begin
        if (!read_cond_c) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    dout_en_d = (rd_state_d == RD_DRIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      dout_q     <= 8'h00;
      dout_en_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
    end
  end

  assign dout_o    = dout_q;
  assign dout_en_o = dout_en_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with TICK_DIV=4, SYNC_STAGES=2.
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n, rd_n, wr_n, ad;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;
  logic       irq_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_bus_responder #(
    .TICK_DIV   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n_i   (cs_n),
    .rd_n_i   (rd_n),
    .wr_n_i   (wr_n),
    .ad_i     (ad),
    .din_i    (din),
    .dout_o   (dout),
    .dout_en_o(dout_en),
    .irq_n_o  (irq_n)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Address phase: one-cycle WR pulse with AD=0, then idle long enough
  // for the synchronised edge to be consumed while Din is still held.
  task automatic bus_addr(input logic [7:0] a);
    @(negedge clk);
    cs_n = 1'b0; ad = 1'b0; din = a; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Data phase write; consecutive calls space WR rising edges 6 cycles apart
  task automatic bus_data(input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; ad = 1'b1; din = d; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr(a);
    bus_data(d);
  endtask

  // Read with exact enable latency checks: high 2 cycles after the pins,
  // low 2 cycles after RD rises.
  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus_addr(a);
    @(negedge clk);
    cs_n = 1'b0; ad = 1'b1; rd_n = 1'b0;
    @(negedge clk);
    check({tag, "_en_lat1"}, 8'(dout_en), 8'h00);
    @(negedge clk);
    check({tag, "_en_lat2"}, 8'(dout_en), 8'h01);
    check({tag, "_data"}, dout, exp);
    rd_n = 1'b1;
    @(negedge clk);
    check({tag, "_en_hold"}, 8'(dout_en), 8'h01);
    @(negedge clk);
    check({tag, "_en_off"}, 8'(dout_en), 8'h00);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Run for exactly one tick window: start and stop writes 6 cycles apart
  task automatic run_one_tick();
    bus_addr(8'h06);
    bus_data(8'h01);
    bus_data(8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; ad = 1'b1; din = 8'h00;
    #2;
    check("rst_dout_en", 8'(dout_en), 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_irq", 8'(irq_n), 8'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_dout_en", 8'(dout_en), 8'h00);

    // Reset CTRL value and stopping the clock
    bus_read(8'h06, 8'h01, "ctrl_reset");
    bus_write(8'h06, 8'h00);
    bus_read(8'h06, 8'h00, "ctrl_stopped");

    // Write/read SEC while stopped
    bus_write(8'h00, 8'h45);
    bus_read(8'h00, 8'h45, "sec_wr");
    bus_read(8'h00, 8'h45, "sec_hold");

    // Unmapped address
    bus_write(8'h0A, 8'h77);
    bus_read(8'h0A, 8'h00, "unmapped");

    // 23:59:59 rolls to 00:00:00 on one tick, then stays frozen
    bus_write(8'h02, 8'h23);
    bus_write(8'h01, 8'h59);
    bus_write(8'h00, 8'h59);
    run_one_tick();
    repeat (20) @(negedge clk);
    bus_read(8'h00, 8'h00, "roll_sec");
    bus_read(8'h01, 8'h00, "roll_min");
    bus_read(8'h02, 8'h00, "roll_hr");
    repeat (20) @(negedge clk);
    bus_read(8'h00, 8'h00, "frozen_sec");

    // Out-of-range SEC wraps to 0x00 and carries into MIN
    bus_write(8'h00, 8'h5A);
    run_one_tick();
    bus_read(8'h00, 8'h00, "oor_sec");
    bus_read(8'h01, 8'h01, "oor_min");

    // Low-nibble 9 carries into the high nibble
    bus_write(8'h00, 8'h19);
    run_one_tick();
    bus_read(8'h00, 8'h20, "bcd_sec");
    bus_read(8'h01, 8'h01, "bcd_min");

    // CTRL bit1 reads back 0
    bus_write(8'h06, 8'h02);
    bus_read(8'h06, 8'h00, "ctrl_bit1");

`ifdef RTC_ALARM_IRQ_EN
    // Alarm at 00:00:02 from 00:00:00
    bus_write(8'h03, 8'h02);
    bus_write(8'h04, 8'h00);
    bus_write(8'h05, 8'h00);
    bus_write(8'h02, 8'h00);
    bus_write(8'h01, 8'h00);
    bus_write(8'h00, 8'h00);
    bus_read(8'h03, 8'h02, "asec_rd");
    bus_addr(8'h06);
    bus_data(8'h01);
    check("irq_before", 8'(irq_n), 8'h01);
    repeat (10) @(negedge clk);
    check("irq_alarm", 8'(irq_n), 8'h00);
    bus_read(8'h07, 8'h01, "status_set");
    bus_write(8'h06, 8'h03);
    check("irq_cleared", 8'(irq_n), 8'h01);
    bus_read(8'h07, 8'h00, "status_clr");
    bus_write(8'h06, 8'h00);
`else
    // Alarm registers and STATUS are absent
    bus_write(8'h03, 8'h12);
    bus_read(8'h03, 8'h00, "asec_absent");
    bus_read(8'h07, 8'h00, "status_absent");
    check("irq_tied", 8'(irq_n), 8'h01);
`endif

    // Reset in the middle of a read
    bus_addr(8'h06);
    @(negedge clk);
    cs_n = 1'b0; ad = 1'b1; rd_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrd_en_before", 8'(dout_en), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("midrd_en_rst", 8'(dout_en), 8'h00);
    check("midrd_dout_rst", dout, 8'h00);
    check("midrd_irq_rst", 8'(irq_n), 8'h01);
    rd_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(8'h06, 8'h01, "post_rst_ctrl");
    bus_read(8'h01, 8'h00, "post_rst_min");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
